// File: rtl/tcu_pkg.sv
// Shared tensor-core definitions: sequencer states, operand format codes
// and the FEDP pipeline depth as a function of row width.
package tcu_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_DONE  = 2'd3
  } tcu_seq_state_e;

  localparam logic [2:0] TCU_FMT_FP16 = 3'd1;
  localparam logic [2:0] TCU_FMT_BF16 = 3'd2;
  localparam logic [2:0] TCU_FMT_TF32 = 3'd3;

  // decode/multiply (3) + align (1) + 3 per adder-tree level over 2N products + normalise/round (3)
  function automatic int TCU_FEDP_LATENCY(input int n);
    return 3 + 1 + 3 * $clog2(2 * n) + 3;
  endfunction

endpackage

// File: rtl/tcu_fedp_seq_wcnt.sv
// Loadable down-counter timing the FEDP pipeline drain; holds at zero and
// flags it so the sequencer knows when fedp_d is valid.
module tcu_fedp_seq_wcnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tcu_fedp_seq.sv
// K-loop sequencer in front of the FEDP: pulls one operand beat per step,
// runs it through the pipeline and feeds the result back as the accumulator.
//
// state | meaning
// IDLE  | ready for a request; acc/fmt/K latched on req handshake
// ISSUE | waiting for an operand beat; beat registered into fedp_a/fedp_b
// WAIT  | FEDP enabled for L+1 cycles; result captured when wcnt hits zero
// DONE  | final accumulator held on rsp_d until rsp_ready
module tcu_fedp_seq
  import tcu_pkg::*;
#(
  parameter int N            = 4,
  parameter int XLEN         = 32,
  parameter int FEDP_LATENCY = TCU_FEDP_LATENCY(N),
  parameter int KW           = 8
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [KW-1:0]     req_k,
  input  logic [2:0]        req_fmt_s,
  input  logic [2:0]        req_fmt_d,
  input  logic [XLEN-1:0]   req_c,

  input  logic              op_valid,
  output logic              op_ready,
  input  logic [N*XLEN-1:0] op_a,
  input  logic [N*XLEN-1:0] op_b,

  output logic              fedp_enable,
  output logic [2:0]        fedp_fmt_s,
  output logic [2:0]        fedp_fmt_d,
  output logic [N*XLEN-1:0] fedp_a,
  output logic [N*XLEN-1:0] fedp_b,
  output logic [XLEN-1:0]   fedp_c,
  input  logic [XLEN-1:0]   fedp_d,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_d,

  output logic              busy
);

  localparam int WCW = $clog2(FEDP_LATENCY + 1);

  tcu_seq_state_e    state_q, state_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [KW-1:0]     rem_q, rem_d;
  logic [2:0]        fmt_s_q, fmt_s_d;
  logic [2:0]        fmt_d_q, fmt_d_d;
  logic [N*XLEN-1:0] a_q, a_d;
  logic [N*XLEN-1:0] b_q, b_d;

  logic wcnt_load;
  logic wcnt_zero;

  assign wcnt_load = (state_q == SEQ_ISSUE) && op_valid;

  tcu_fedp_seq_wcnt #(
    .W (WCW)
  ) u_wcnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (wcnt_load),
    .load_val_i (WCW'(FEDP_LATENCY)),
    .dec_i      (state_q == SEQ_WAIT),
    .zero_o     (wcnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE: begin
        if (req_valid) begin
          state_d = (req_k == '0) ? SEQ_DONE : SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        if (op_valid) begin
          state_d = SEQ_WAIT;
        end
      end
      SEQ_WAIT: begin
        if (wcnt_zero) begin
          state_d = (rem_q == KW'(1)) ? SEQ_DONE : SEQ_ISSUE;
        end
      end
      SEQ_DONE: begin
        if (rsp_ready) begin
          state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    op_ready    = 1'b0;
    fedp_enable = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    case (state_q)
      SEQ_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      SEQ_ISSUE: op_ready    = 1'b1;
      SEQ_WAIT:  fedp_enable = 1'b1;
      SEQ_DONE:  rsp_valid   = 1'b1;
      default:   busy        = 1'b1;
    endcase
  end

  // Datapath: everything the FEDP and response port see is registered
  always_comb begin
    acc_d   = acc_q;
    rem_d   = rem_q;
    fmt_s_d = fmt_s_q;
    fmt_d_d = fmt_d_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      SEQ_IDLE: begin
        if (req_valid) begin
          fmt_s_d = req_fmt_s;
          fmt_d_d = req_fmt_d;
          acc_d   = req_c;
          rem_d   = req_k;
        end
      end
      SEQ_ISSUE: begin
        if (op_valid) begin
          a_d = op_a;
          b_d = op_b;
        end
      end
      SEQ_WAIT: begin
        if (wcnt_zero) begin
          acc_d = fedp_d;
          rem_d = rem_q - KW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      rem_q   <= '0;
      fmt_s_q <= '0;
      fmt_d_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      fmt_s_q <= fmt_s_d;
      fmt_d_q <= fmt_d_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign fedp_fmt_s = fmt_s_q;
  assign fedp_fmt_d = fmt_d_q;
  assign fedp_a     = a_q;
  assign fedp_b     = b_q;
  assign fedp_c     = acc_q;
  assign rsp_d      = acc_q;

endmodule

// File: tb/tb_tcu_fedp_seq.sv
// Scoreboard bench for tcu_fedp_seq with a stand-in fp16 FEDP pipeline;
// directed test-plan cases followed by randomized requests.
module tb_tcu_fedp_seq;
  import tcu_pkg::*;

  localparam int N    = 4;
  localparam int XLEN = 32;
  localparam int L    = 16;
  localparam int KW   = 8;
  localparam int NX   = N * XLEN;
  localparam int MAXK = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            req_valid, req_ready;
  logic [KW-1:0]   req_k;
  logic [2:0]      req_fmt_s, req_fmt_d;
  logic [XLEN-1:0] req_c;
  logic            op_valid, op_ready;
  logic [NX-1:0]   op_a, op_b;
  logic            fedp_enable;
  logic [2:0]      fedp_fmt_s, fedp_fmt_d;
  logic [NX-1:0]   fedp_a, fedp_b;
  logic [XLEN-1:0] fedp_c, fedp_d;
  logic            rsp_valid, rsp_ready;
  logic [XLEN-1:0] rsp_d;
  logic            busy;

  tcu_fedp_seq #(.N(N), .XLEN(XLEN), .FEDP_LATENCY(L), .KW(KW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_k(req_k),
    .req_fmt_s(req_fmt_s), .req_fmt_d(req_fmt_d), .req_c(req_c),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .fedp_enable(fedp_enable), .fedp_fmt_s(fedp_fmt_s), .fedp_fmt_d(fedp_fmt_d),
    .fedp_a(fedp_a), .fedp_b(fedp_b), .fedp_c(fedp_c), .fedp_d(fedp_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d(rsp_d),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // fp16 / fp32 <-> real via IEEE double bit patterns
  function automatic real h2r(input logic [15:0] h);
    logic [10:0] e;
    if (h[14:10] == 5'd0) return 0.0;
    e = {6'd0, h[14:10]} + 11'd1008;
    return $bitstoreal({h[15], e, h[9:0], 42'd0});
  endfunction

  function automatic real f2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'd0) return 0.0;
    e = {3'd0, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [10:0] e;
    b = $realtobits(r);
    if (b[62:0] == 63'd0) return 32'd0;
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // c + sum over all 2N half-word products, truncated to fp32
  function automatic logic [31:0] fedp_fn(input logic [NX-1:0] a, input logic [NX-1:0] b,
                                          input logic [31:0] c);
    real s;
    s = f2r(c);
    for (int i = 0; i < 2 * N; i++) s = s + h2r(a[16*i +: 16]) * h2r(b[16*i +: 16]);
    return r2f(s);
  endfunction

  // Stand-in FEDP: L enable-gated stages
  logic [31:0] fpipe [L];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < L; i++) fpipe[i] <= 32'd0;
    end else if (fedp_enable) begin
      fpipe[0] <= fedp_fn(fedp_a, fedp_b, fedp_c);
      for (int i = 1; i < L; i++) fpipe[i] <= fpipe[i-1];
    end
  end
  assign fedp_d = fpipe[L-1];

  typedef struct {
    logic [NX-1:0] a;
    logic [NX-1:0] b;
    int            stall;
  } beat_t;

  typedef struct {
    int            k;
    int            rise;
    int            stall;
    logic [2:0]    fs;
    logic [2:0]    fd;
    logic [31:0]   d;
    logic [31:0]   accs [MAXK];
    logic [NX-1:0] a [MAXK];
    logic [NX-1:0] b [MAXK];
  } exp_t;

  beat_t op_q [$];
  exp_t  sb_q [$];
  int    rsp_hold = 0;
  logic [31:0] last_rsp_d = 32'd0;

  // Operand driver: beat offered only while op_ready, after its stall budget
  initial begin
    beat_t bt;
    op_valid = 1'b0; op_a = '0; op_b = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        op_valid = 1'b0;
      end else begin
        if (op_valid) op_valid = 1'b0;
        if (op_ready && op_q.size() > 0) begin
          if (op_q[0].stall > 0) begin
            op_q[0].stall = op_q[0].stall - 1;
          end else begin
            bt = op_q.pop_front();
            op_a = bt.a; op_b = bt.b; op_valid = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rsp_valid && rsp_hold > 0) begin
        rsp_ready = 1'b0;
        rsp_hold  = rsp_hold - 1;
      end else begin
        rsp_ready = 1'b1;
      end
    end
  end

  // Monitor: samples mid-cycle, pops the scoreboard on the response handshake
  exp_t cur;
  bit   active = 0, rv_prev = 0, post_hs = 0;
  int   t0 = 0, hs = 0, en = 0, rdy = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      active = 0; rv_prev = 0; post_hs = 0;
    end else begin
      if (post_hs) begin
        chk("req_ready_after_rsp", req_ready, 1);
        post_hs = 0;
      end
      if (active && cyc > t0) begin
        chk("req_ready_busy", req_ready, 0);
        chk("busy", busy, 1);
        chk("fmt_s", fedp_fmt_s, cur.fs);
        chk("fmt_d", fedp_fmt_d, cur.fd);
        if (op_ready) begin
          rdy++;
          chk("issue_en", fedp_enable, 0);
          chk("issue_rsp_valid", rsp_valid, 0);
          if (hs < MAXK) chk("issue_c", fedp_c, cur.accs[hs]);
          if (op_valid) hs++;
        end
        if (fedp_enable) begin
          en++;
          chk("wait_op_ready", op_ready, 0);
          if (hs > 0 && hs <= MAXK) begin
            chk("wait_c", fedp_c, cur.accs[hs-1]);
            chk("wait_a", fedp_a, cur.a[hs-1]);
            chk("wait_b", fedp_b, cur.b[hs-1]);
          end
        end
        if (rsp_valid) begin
          if (!rv_prev) chk("rsp_rise_cycle", cyc - t0, cur.rise);
          chk("rsp_d", rsp_d, cur.d);
          chk("done_en", fedp_enable, 0);
          chk("done_op_ready", op_ready, 0);
          if (rsp_ready) begin
            chk("op_handshakes", hs, cur.k);
            chk("en_cycles", en, cur.k * (L + 1));
            chk("op_ready_cycles", rdy, cur.k + cur.stall);
            last_rsp_d = rsp_d;
            void'(sb_q.pop_front());
            active  = 0;
            post_hs = 1;
          end
        end
        rv_prev = rsp_valid;
      end
      if (req_valid && req_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_request", 0, 1);
        end else begin
          cur = sb_q[0];
          active = 1; t0 = cyc; hs = 0; en = 0; rdy = 0; rv_prev = 0;
        end
      end
    end
  end

  function automatic logic [NX-1:0] rnd_beat();
    logic [NX-1:0] v;
    for (int i = 0; i < 2 * N; i++)
      v[16*i +: 16] = {1'($urandom_range(1, 0)), 5'($urandom_range(16, 13)), 10'($urandom)};
    return v;
  endfunction

  // Builds the expected result from the operand list, queues beats, drives the request
  task automatic issue(input int k, input logic [31:0] c, input logic [2:0] fs,
                       input logic [2:0] fd, input bit rnd_ops, input bit rnd_stall,
                       input int stall_at, input int stall_len, input int hold);
    exp_t  e;
    beat_t bt;
    logic [31:0] acc;
    int tot, w;
    acc = c; tot = 0;
    for (int j = 0; j < k; j++) begin
      bt.a = rnd_ops ? rnd_beat() : {(2 * N){16'h3C00}};
      bt.b = rnd_ops ? rnd_beat() : {(2 * N){16'h4000}};
      bt.stall = rnd_stall ? int'($urandom_range(3, 0)) : ((j == stall_at) ? stall_len : 0);
      e.accs[j] = acc;
      e.a[j] = bt.a;
      e.b[j] = bt.b;
      acc = fedp_fn(bt.a, bt.b, acc);
      tot += bt.stall;
      op_q.push_back(bt);
    end
    if (k < MAXK) e.accs[k] = acc;
    e.k = k; e.d = acc; e.fs = fs; e.fd = fd; e.stall = tot;
    e.rise = k * (L + 2) + 1 + tot;
    sb_q.push_back(e);
    rsp_hold = hold;
    req_k = KW'(k); req_c = c; req_fmt_s = fs; req_fmt_d = fd; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("req_accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", sb_q.size(), 0);
    chk("op_q_empty", op_q.size(), 0);
    sb_q.delete();
    op_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_k = '0; req_c = '0;
    req_fmt_s = '0; req_fmt_d = '0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_fedp_enable", fedp_enable, 0);
    chk("rst_fedp_c", fedp_c, 0);

    issue(1, 32'h3F800000, TCU_FMT_FP16, TCU_FMT_FP16, 0, 0, 0, 0, 0);
    drain();
    chk("k1_fp16_result", last_rsp_d, 32'h41880000);

    issue(2, 32'h3F800000, TCU_FMT_FP16, TCU_FMT_FP16, 0, 0, 0, 0, 0);
    drain();
    chk("k2_fp16_result", last_rsp_d, 32'h42040000);

    issue(0, 32'h12345678, TCU_FMT_BF16, TCU_FMT_TF32, 0, 0, 0, 0, 0);
    drain();
    chk("k0_result", last_rsp_d, 32'h12345678);

    issue(2, 32'h3F800000, TCU_FMT_FP16, TCU_FMT_FP16, 0, 0, 1, 5, 3);
    drain();
    chk("stall_result", last_rsp_d, 32'h42040000);

    // Reset in the middle of step 1's WAIT of a K=3 request
    issue(3, 32'h3F800000, TCU_FMT_FP16, TCU_FMT_FP16, 0, 0, 0, 0, 0);
    repeat (27) @(posedge clk);
    #3;
    chk("pre_reset_wait", fedp_enable, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_op_ready", op_ready, 0);
    chk("arst_fedp_enable", fedp_enable, 0);
    chk("arst_fedp_c", fedp_c, 0);
    chk("arst_fedp_a", fedp_a, 0);
    chk("arst_fedp_b", fedp_b, 0);
    chk("arst_rsp_d", rsp_d, 0);
    sb_q.delete();
    op_q.delete();
    rsp_hold = 0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    issue(1, 32'h3F800000, TCU_FMT_FP16, TCU_FMT_FP16, 0, 0, 0, 0, 0);
    drain();
    chk("post_reset_result", last_rsp_d, 32'h41880000);

    for (int r = 0; r < 20; r++) begin
      issue(int'($urandom_range(6, 0)),
            {1'($urandom_range(1, 0)), 8'($urandom_range(130, 124)), 23'($urandom)},
            3'($urandom_range(7, 0)), 3'($urandom_range(3, 1)),
            1, 1, 0, 0, int'($urandom_range(3, 0)));
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
